// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS main controller.
// Holds the FSM state encoding, the opcode and funct values the controller
// recognises, and the datapath select encodings the controller drives.
// No ports; imported by mips_alu_decoder and mips_multicycle_ctrl.
package mips_multicycle_ctrl_pkg;

  // The encoding is visible on the debug state port, so keep it stable.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExec   = 4'd2,
    StRwb    = 4'd3,
    StMemAdr = 4'd4,
    StMemRd  = 4'd5,
    StLwb    = 4'd6,
    StMemWr  = 4'd7,
    StBeq    = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12
  } ctrl_state_t;

  typedef enum logic [5:0] {
    OpRtype = 6'b000000,
    OpJ     = 6'b000010,
    OpJal   = 6'b000011,
    OpBeq   = 6'b000100,
    OpAddi  = 6'b001000,
    OpLw    = 6'b100011,
    OpSw    = 6'b101011
  } opcode_t;

  typedef enum logic [5:0] {
    FnAdd = 6'b100000,
    FnSub = 6'b100010,
    FnAnd = 6'b100100,
    FnOr  = 6'b100101,
    FnSlt = 6'b101010
  } funct_t;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    PcAluResult = 2'b00,
    PcAluOut    = 2'b01,
    PcJump      = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    SrcBReg    = 2'b00,
    SrcBFour   = 2'b01,
    SrcBImm    = 2'b10,
    SrcBImmSh2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    DstRt = 2'b00,
    DstRd = 2'b01,
    DstRa = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    WdAluOut = 2'b00,
    WdMdr    = 2'b01,
    WdPc     = 2'b10
  } wd_src_t;

  // States that hold a memory request open and wait for mem_ready.
  function automatic logic is_wait_state(ctrl_state_t s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder for the multicycle controller.
// Ports:
//   funct         in  IR[5:0]
//   alu_ctrl      out ALU operation for the EXEC step
//   illegal_funct out funct is not one of add/sub/and/or/slt
module mips_alu_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output alu_ctrl_t  alu_ctrl,
  output logic       illegal_funct
);

  always_comb begin
    alu_ctrl      = AluAdd;
    illegal_funct = 1'b0;
    case (funct)
      FnAdd:   alu_ctrl = AluAdd;
      FnSub:   alu_ctrl = AluSub;
      FnAnd:   alu_ctrl = AluAnd;
      FnOr:    alu_ctrl = AluOr;
      FnSlt:   alu_ctrl = AluSlt;
      default: illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core. Sequences the shared memory
// port, IR, register file, ALU and PC through fetch/decode/execute/memory/
// writeback steps and drives every datapath enable and mux select.
// Ports:
//   clock, reset       clock; synchronous active-high reset
//   opcode, funct      IR[31:26], IR[5:0]
//   zero               ALU zero flag (BEQ decision)
//   mem_ready          memory finished the current request this cycle
//   mem_req, mem_we    memory request / write qualifier, held until mem_ready
//   iord               memory address select (0 PC, 1 ALUOut)
//   ir_we, pc_we       IR latch and PC write enables
//   pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_dst, wd_src   datapath selects
//   rf_we              register-file write
//   instr_done         one-cycle pulse on retirement
//   illegal            one-cycle pulse on unsupported opcode/funct
//   mem_err            sticky memory-timeout flag
//   state              current FSM state (debug)
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       rf_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_src,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  // Wide enough to hold FETCH_TIMEOUT itself (counter saturates there).
  localparam int unsigned CntW = $clog2(FETCH_TIMEOUT + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(FETCH_TIMEOUT);

  ctrl_state_t     state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            mem_err_q, mem_err_d;
  logic            waiting;

  alu_ctrl_t dec_alu_ctrl;
  logic      dec_illegal;

  mips_alu_decoder u_alu_decoder (
    .funct         (funct),
    .alu_ctrl      (dec_alu_ctrl),
    .illegal_funct (dec_illegal)
  );

  // Timeout counter: only counts stalled cycles of a request state; any
  // completed handshake or any other state clears it.
  assign waiting = is_wait_state(state_q) && !mem_ready;

  always_comb begin
    count_d = '0;
    if (waiting) begin
      count_d = (count_q != CntMax) ? count_q + CntW'(1) : count_q;
    end
    mem_err_d = mem_err_q;
    if ((FETCH_TIMEOUT != 0) && waiting && (count_d == CntMax)) begin
      mem_err_d = 1'b1;
    end
  end

  // Next state and outputs. Everything is decoded from state_q except the
  // mem_ready-qualified IR/PC writes in fetch and the zero-qualified BEQ
  // PC write. While reset is high every output is held at zero.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PcAluResult;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    alu_ctrl   = AluAnd;
    rf_we      = 1'b0;
    reg_dst    = DstRt;
    wd_src     = WdAluOut;
    instr_done = 1'b0;
    illegal    = 1'b0;

    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_src_b = SrcBFour;
          alu_ctrl  = AluAdd;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          // Branch target is computed speculatively into ALUOut here.
          alu_src_b = SrcBImmSh2;
          alu_ctrl  = AluAdd;
          case (opcode)
            OpRtype:    state_d = StExec;
            OpLw, OpSw: state_d = StMemAdr;
            OpBeq:      state_d = StBeq;
            OpAddi:     state_d = StAddiEx;
            OpJ:        state_d = StJump;
            OpJal:      state_d = StJal;
            default: begin
              illegal = 1'b1;
              state_d = StFetch;
            end
          endcase
        end
        StExec: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBReg;
          alu_ctrl  = dec_alu_ctrl;
          if (dec_illegal) begin
            illegal = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StRwb;
          end
        end
        StRwb: begin
          rf_we      = 1'b1;
          reg_dst    = DstRd;
          wd_src     = WdAluOut;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemAdr: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
          alu_ctrl  = AluAdd;
          state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
        end
        StMemRd: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = StLwb;
        end
        StLwb: begin
          rf_we      = 1'b1;
          reg_dst    = DstRt;
          wd_src     = WdMdr;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemWr: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        end
        StBeq: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SrcBReg;
          alu_ctrl   = AluSub;
          pc_src     = PcAluOut;
          pc_we      = zero;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StAddiEx: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
          alu_ctrl  = AluAdd;
          state_d   = StAddiWb;
        end
        StAddiWb: begin
          rf_we      = 1'b1;
          reg_dst    = DstRt;
          wd_src     = WdAluOut;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StJump: begin
          pc_src     = PcJump;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StJal: begin
          // PC already holds the return address (+4 applied in fetch).
          rf_we      = 1'b1;
          reg_dst    = DstRa;
          wd_src     = WdPc;
          pc_src     = PcJump;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      count_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q && !reset;
  assign state   = reset ? StFetch : state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for a multicycle variant of the MIPS core. It sequences one shared memory port, the IR, the register file, the ALU and the PC across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps, instead of the single-cycle decode. Memory accesses use a request/ready handshake so variable-latency instruction and data memories can be attached. It sits in the MIPS top beside the datapath and drives every datapath enable and mux select.

Parameters:
FETCH_TIMEOUT, 8, cycles without mem_ready before mem_err asserts (0 disables the check).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req
iord  out  1  0 = address from PC, 1 = address from ALUOut
ir_we  out  1  latch IR
pc_we  out  1  unconditional PC write
pc_src  out  2  00 ALU result, 01 ALUOut (branch), 10 jump target
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
rf_we  out  1  register-file write
reg_dst  out  2  00 rt, 01 rd, 10 REG_31
wd_src  out  2  00 ALUOut, 01 MDR, 10 PC (link)
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse on unsupported opcode/funct
mem_err  out  1  sticky until reset, fetch timeout
state  out  4  current state (debug)

Behaviour:
- Reset (sampled on posedge clock): state = FETCH, all outputs 0, timeout counter 0, mem_err cleared. Reset overrides any pending memory handshake.
- Outputs are Moore (decoded from state) except pc_we in BEQ (= zero) and the mem_ready-qualified ir_we/pc_we in FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add. While !mem_ready, stay. On mem_ready: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode: 000000 R-type -> EXEC; 100011 lw / 101011 sw -> MEMADR; 000100 beq -> BEQ; 001000 addi -> ADDIEX; 000010 j -> JUMP; 000011 jal -> JAL; otherwise illegal=1, -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Unknown funct: illegal=1, -> FETCH, no writeback. Otherwise -> RWB.
- RWB: rf_we=1, reg_dst=01, wd_src=00, instr_done=1, -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1; hold until mem_ready, then -> LWB. LWB: rf_we=1, reg_dst=00, wd_src=01, instr_done=1, -> FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; hold until mem_ready; in that cycle instr_done=1, -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_we=zero, instr_done=1, -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, -> ADDIWB. ADDIWB: rf_we=1, reg_dst=00, wd_src=00, instr_done=1, -> FETCH.
- JUMP: pc_src=10, pc_we=1, instr_done=1, -> FETCH.
- JAL: rf_we=1, reg_dst=10, wd_src=10 (link = PC already +4), pc_src=10, pc_we=1, instr_done=1, -> FETCH.
- Timeout counter runs only in FETCH/MEMRD/MEMWR while !mem_ready. It clears on mem_ready and on state exit. When it reaches FETCH_TIMEOUT, mem_err is set. The FSM keeps waiting; there is no abort.
- mem_req and mem_we must stay stable while waiting. mem_ready outside a request state is ignored.
- CPI: R/addi 4, lw 5, sw 4, beq/j/jal 3, with zero-wait memory. Each wait cycle adds 1.

Decomposition:
- Add to global_types: ctrl_state_t enum (FETCH..JAL), opcode_t/funct_t enums, alu_ctrl_t, pc_src_t, alu_src_b_t, reg_dst_t, wd_src_t.
- One sub-module: mips_alu_decoder (combinational funct -> alu_ctrl + illegal_funct).
- FSM, output decode and timeout counter stay in mips_multicycle_ctrl.

Test Plan:
1. Reset held 2 cycles, then released with mem_ready=1 and opcode=000000/funct=100000 -> states FETCH, DECODE, EXEC, RWB. Require rf_we=1, reg_dst=01 in RWB, instr_done exactly once, back in FETCH on cycle 5.
2. lw (100011) with mem_ready low 3 cycles in MEMRD -> mem_req=1, iord=1 held 3 cycles. LWB follows on the ready cycle with wd_src=01; total 8 cycles.
3. beq with zero=1, then zero=0 -> pc_we=1 with pc_src=01 in the first case, pc_we=0 in the second; both retire in 3 cycles.
4. jal (000011) -> in the JAL state, rf_we=1, reg_dst=10, wd_src=10, pc_we=1, pc_src=10 in the same cycle.
5. opcode=111111 and R-type funct=000111 -> illegal pulses one cycle, no rf_we, FSM returns to FETCH.
6. mem_ready low 8 cycles in FETCH -> mem_err=1 and stays 1 after mem_ready returns. Synchronous reset asserted mid-MEMWR -> next cycle state=FETCH, mem_we=0, mem_err=0.
